// File: rtl/reg_status_pkg.sv
// reg_status_pkg
// Shared constants and helpers for the register status table.
//   TAG_READY      : tag value meaning "no pending producer, value is valid"
//   DEF_WORD/TAG_W/NREG : default data width, FU tag width, register count
//   log2_ceil()    : ceiling log2, used to size register index fields
package reg_status_pkg;

    localparam int TAG_READY = 0;
    localparam int DEF_WORD  = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_NREG  = 32;

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Multiport architectural value array: RD_PORTS combinational read ports and
// a per-register write-enable vector sharing one write-data bus.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-high, clears every entry to 0
//   we      : NREG write enables, bit r writes wdata into entry r
//   wdata   : shared write data
//   rd_idx  : RD_PORTS packed read indices, port 0 in the LSBs
//   rd_data : RD_PORTS packed read values, port 0 in the LSBs
module reg_file_mp
    import reg_status_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int WORD     = DEF_WORD,
    parameter int RD_PORTS = 3,
    localparam int IDX_W   = log2_ceil(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREG-1:0]           we,
    input  logic [WORD-1:0]           wdata,
    input  logic [RD_PORTS*IDX_W-1:0] rd_idx,
    output logic [RD_PORTS*WORD-1:0]  rd_data
);

    logic [WORD-1:0] mem [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (we[r]) mem[r] <= wdata;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_data[p*WORD +: WORD] = mem[rd_idx[p*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/reg_status_table.sv
// reg_status_table
// Tomasulo register status table: architectural values plus, per register,
// the tag of the functional unit that will produce the next value.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   rd_idx              : RD_PORTS packed read indices (port 0 in LSBs)
//   rd_value/rd_tag     : combinational value and producer tag per read port
//   rd_ready            : per port, high when the producer tag is READY (0)
//   rn_en/rn_idx/rn_tag : RN_PORTS rename requests, higher index is younger
//   cdb_valid/tag/data  : common data bus broadcast
//   flush               : marks every register READY, values untouched
//   busy_count          : registered count of registers with a pending tag
// Optional feature macro RS_CDB_BYPASS_EN: when defined, a read port whose
// stored tag matches the live CDB broadcast shows the broadcast data as READY
// in the same cycle.  Sequential behaviour does not depend on the macro.
// Register 0 is hardwired: it is never written and never renamed.
module reg_status_table
    import reg_status_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int WORD     = DEF_WORD,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int RD_PORTS = 3,
    parameter int RN_PORTS = 2,
    localparam int IDX_W   = log2_ceil(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RD_PORTS*IDX_W-1:0] rd_idx,
    output logic [RD_PORTS*WORD-1:0]  rd_value,
    output logic [RD_PORTS*TAG_W-1:0] rd_tag,
    output logic [RD_PORTS-1:0]       rd_ready,
    input  logic [RN_PORTS-1:0]       rn_en,
    input  logic [RN_PORTS*IDX_W-1:0] rn_idx,
    input  logic [RN_PORTS*TAG_W-1:0] rn_tag,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_tag,
    input  logic [WORD-1:0]           cdb_data,
    input  logic                      flush,
    output logic [IDX_W:0]            busy_count
);

    localparam logic [TAG_W-1:0] READY = TAG_W'(TAG_READY);

    logic [TAG_W-1:0]          tags     [NREG];
    logic [TAG_W-1:0]          tag_nxt  [NREG];
    logic [NREG-1:0]           cdb_hit;
    logic [IDX_W:0]            busy_nxt;
    logic [RD_PORTS*WORD-1:0]  rf_rd_data;
    logic                      cdb_live;

    // A broadcast of tag 0 would match every READY register, so it is ignored.
    assign cdb_live = cdb_valid && (cdb_tag != READY);

    // Next-state tags.  Priority, lowest to highest: hold, CDB clear, renames
    // in port order (younger port wins), flush.  All matches use the tags
    // from before the edge.
    always_comb begin
        cdb_hit    = '0;
        tag_nxt[0] = READY;
        for (int r = 1; r < NREG; r++) begin
            cdb_hit[r] = cdb_live && (tags[r] == cdb_tag);
            tag_nxt[r] = cdb_hit[r] ? READY : tags[r];
            for (int k = 0; k < RN_PORTS; k++) begin
                if (rn_en[k] && (rn_idx[k*IDX_W +: IDX_W] == IDX_W'(r))) begin
                    tag_nxt[r] = rn_tag[k*TAG_W +: TAG_W];
                end
            end
            if (flush) tag_nxt[r] = READY;
        end
    end

    // Popcount of the next-state tags so busy_count tracks the table exactly.
    always_comb begin
        busy_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_nxt = busy_nxt + (IDX_W+1)'(tag_nxt[r] != READY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) tags[r] <= READY;
            busy_count <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) tags[r] <= tag_nxt[r];
            busy_count <= busy_nxt;
        end
    end

    // Value writes follow the pre-edge tag match only; renames and flush
    // never suppress them.
    reg_file_mp #(
        .NREG     (NREG),
        .WORD     (WORD),
        .RD_PORTS (RD_PORTS)
    ) u_values (
        .clk     (clk),
        .reset   (reset),
        .we      (cdb_hit),
        .wdata   (cdb_data),
        .rd_idx  (rd_idx),
        .rd_data (rf_rd_data)
    );

    always_comb begin
        logic [TAG_W-1:0] st;
        rd_value = rf_rd_data;
        rd_tag   = '0;
        rd_ready = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            st                       = tags[rd_idx[p*IDX_W +: IDX_W]];
            rd_tag[p*TAG_W +: TAG_W] = st;
            rd_ready[p]              = (st == READY);
`ifdef RS_CDB_BYPASS_EN
            if (cdb_live && (st == cdb_tag)) begin
                rd_value[p*WORD +: WORD]  = cdb_data;
                rd_tag[p*TAG_W +: TAG_W]  = READY;
                rd_ready[p]               = 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
module tb_reg_status_table;

    localparam int NREG = 32;
    localparam int WORD = 32;
    localparam int TAG_W = 4;
    localparam int RDP = 3;
    localparam int RNP = 2;
    localparam int IW = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [RDP*IW-1:0]   rd_idx;
    logic [RDP*WORD-1:0] rd_value;
    logic [RDP*TAG_W-1:0] rd_tag;
    logic [RDP-1:0]      rd_ready;
    logic [RNP-1:0]      rn_en;
    logic [RNP*IW-1:0]   rn_idx;
    logic [RNP*TAG_W-1:0] rn_tag;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [WORD-1:0]     cdb_data;
    logic                flush;
    logic [IW:0]         busy_count;

    int tests = 0;
    int fails = 0;

    reg_status_table #(
        .NREG(NREG), .WORD(WORD), .TAG_W(TAG_W), .RD_PORTS(RDP), .RN_PORTS(RNP)
    ) dut (
        .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_value(rd_value),
        .rd_tag(rd_tag), .rd_ready(rd_ready), .rn_en(rn_en), .rn_idx(rn_idx),
        .rn_tag(rn_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .flush(flush), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD-1:0] val(input int p);
        return rd_value[p*WORD +: WORD];
    endfunction

    function automatic logic [TAG_W-1:0] tg(input int p);
        return rd_tag[p*TAG_W +: TAG_W];
    endfunction

    // One clock edge, then return control inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        rn_en = '0;
        cdb_valid = 1'b0;
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rd_idx = {3{5'd5}};
        #2;
        tests++; if (rd_value !== '0) begin fails++; $display("FAIL reset_async_value: got %h expected 0", rd_value); end
        tests++; if (rd_tag !== '0) begin fails++; $display("FAIL reset_async_tag: got %h expected 0", rd_tag); end
        tests++; if (rd_ready !== 3'b111) begin fails++; $display("FAIL reset_async_ready: got %b expected 111", rd_ready); end
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL reset_async_busy: got %0d expected 0", busy_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests++; if (val(1) !== 32'h0) begin fails++; $display("FAIL reset_r5_value: got %h expected 0", val(1)); end
        tests++; if (tg(2) !== 4'd0) begin fails++; $display("FAIL reset_r5_tag: got %0d expected 0", tg(2)); end
        tests++; if (rd_ready !== 3'b111) begin fails++; $display("FAIL reset_r5_ready: got %b expected 111", rd_ready); end
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL reset_busy: got %0d expected 0", busy_count); end
    endtask

    task automatic test_rename_cdb();
        rd_idx = {3{5'd5}};
        rn_en = 2'b01; rn_idx = {5'd0, 5'd5}; rn_tag = {4'd0, 4'd3};
        tick();
        tests++; if (tg(0) !== 4'd3) begin fails++; $display("FAIL rn_tag_r5: got %0d expected 3", tg(0)); end
        tests++; if (rd_ready[0] !== 1'b0) begin fails++; $display("FAIL rn_ready_r5: got %b expected 0", rd_ready[0]); end
        tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL rn_busy: got %0d expected 1", busy_count); end
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'hDEADBEEF;
        #1;
`ifdef RS_CDB_BYPASS_EN
        tests++; if (val(2) !== 32'hDEADBEEF) begin fails++; $display("FAIL byp_r5_value: got %h expected deadbeef", val(2)); end
`else
        tests++; if (tg(2) !== 4'd3) begin fails++; $display("FAIL nobyp_r5_tag: got %0d expected 3", tg(2)); end
`endif
        tick();
        tests++; if (val(0) !== 32'hDEADBEEF) begin fails++; $display("FAIL cdb_r5_value: got %h expected deadbeef", val(0)); end
        tests++; if (tg(1) !== 4'd0) begin fails++; $display("FAIL cdb_r5_tag: got %0d expected 0", tg(1)); end
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL cdb_busy: got %0d expected 0", busy_count); end
    endtask

    task automatic test_rename_priority();
        rd_idx = {3{5'd7}};
        rn_en = 2'b11; rn_idx = {5'd7, 5'd7}; rn_tag = {4'd4, 4'd2};
        tick();
        tests++; if (tg(0) !== 4'd4) begin fails++; $display("FAIL prio_r7_tag: got %0d expected 4", tg(0)); end
        tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL prio_busy: got %0d expected 1", busy_count); end
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hAAAA5555;
        tick();
        tests++; if (tg(1) !== 4'd4) begin fails++; $display("FAIL stale_cdb_r7_tag: got %0d expected 4", tg(1)); end
        tests++; if (val(2) !== 32'h0) begin fails++; $display("FAIL stale_cdb_r7_value: got %h expected 0", val(2)); end
    endtask

    task automatic test_cdb_rename_same();
        rd_idx = {5'd7, 5'd9, 5'd9};
        rn_en = 2'b10; rn_idx = {5'd9, 5'd0}; rn_tag = {4'd6, 4'd0};
        tick();
        tests++; if (busy_count !== 6'd2) begin fails++; $display("FAIL r9_busy: got %0d expected 2", busy_count); end
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h55;
        rn_en = 2'b01; rn_idx = {5'd0, 5'd9}; rn_tag = {4'd0, 4'd1};
        tick();
        tests++; if (val(0) !== 32'h55) begin fails++; $display("FAIL same_r9_value: got %h expected 55", val(0)); end
        tests++; if (tg(1) !== 4'd1) begin fails++; $display("FAIL same_r9_tag: got %0d expected 1", tg(1)); end
        tests++; if (tg(2) !== 4'd4) begin fails++; $display("FAIL same_r7_tag: got %0d expected 4", tg(2)); end
        tests++; if (busy_count !== 6'd2) begin fails++; $display("FAIL same_busy: got %0d expected 2", busy_count); end
    endtask

    task automatic test_flush();
        // Mid-operation reset discards r7/r9 renames and the r9 value.
        rd_idx = {5'd7, 5'd9, 5'd9};
        reset = 1'b1;
        #1;
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL midreset_busy: got %0d expected 0", busy_count); end
        tests++; if (rd_ready !== 3'b111) begin fails++; $display("FAIL midreset_ready: got %b expected 111", rd_ready); end
        tests++; if (val(0) !== 32'h0) begin fails++; $display("FAIL midreset_r9_value: got %h expected 0", val(0)); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_idx = {5'd4, 5'd2, 5'd1};
        rn_en = 2'b01; rn_idx = {5'd0, 5'd1}; rn_tag = {4'd0, 4'd1};
        tick();
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h77;
        tick();
        rn_en = 2'b11; rn_idx = {5'd2, 5'd1}; rn_tag = {4'd2, 4'd1};
        tick();
        rn_en = 2'b01; rn_idx = {5'd0, 5'd3}; rn_tag = {4'd0, 4'd3};
        tick();
        tests++; if (busy_count !== 6'd3) begin fails++; $display("FAIL preflush_busy: got %0d expected 3", busy_count); end
        flush = 1'b1;
        rn_en = 2'b01; rn_idx = {5'd0, 5'd4}; rn_tag = {4'd0, 4'd5};
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h99;
        tick();
        tests++; if (rd_tag !== '0) begin fails++; $display("FAIL flush_tags: got %h expected 0", rd_tag); end
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL flush_busy: got %0d expected 0", busy_count); end
        tests++; if (val(0) !== 32'h77) begin fails++; $display("FAIL flush_r1_value: got %h expected 77", val(0)); end
        tests++; if (val(1) !== 32'h99) begin fails++; $display("FAIL flush_r2_cdbwrite: got %h expected 99", val(1)); end
        tests++; if (val(2) !== 32'h0) begin fails++; $display("FAIL flush_r4_value: got %h expected 0", val(2)); end
    endtask

    task automatic test_ignored();
        rd_idx = {5'd1, 5'd0, 5'd0};
        rn_en = 2'b10; rn_idx = {5'd0, 5'd0}; rn_tag = {4'd7, 4'd0};
        tick();
        tests++; if (tg(0) !== 4'd0) begin fails++; $display("FAIL r0_rename_tag: got %0d expected 0", tg(0)); end
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL r0_rename_busy: got %0d expected 0", busy_count); end
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'hFFFF;
        tick();
        tests++; if (val(2) !== 32'h77) begin fails++; $display("FAIL tag0_cdb_r1_value: got %h expected 77", val(2)); end
        tests++; if (val(1) !== 32'h0) begin fails++; $display("FAIL tag0_cdb_r0_value: got %h expected 0", val(1)); end
    endtask

    task automatic test_bypass();
        rd_idx = {5'd10, 5'd10, 5'd1};
        rn_en = 2'b01; rn_idx = {5'd0, 5'd10}; rn_tag = {4'd0, 4'd2};
        tick();
        tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL byp_setup_busy: got %0d expected 1", busy_count); end
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h1234;
        #1;
`ifdef RS_CDB_BYPASS_EN
        tests++; if (val(1) !== 32'h1234) begin fails++; $display("FAIL byp_value: got %h expected 1234", val(1)); end
        tests++; if (tg(1) !== 4'd0) begin fails++; $display("FAIL byp_tag: got %0d expected 0", tg(1)); end
        tests++; if (rd_ready[1] !== 1'b1) begin fails++; $display("FAIL byp_ready: got %b expected 1", rd_ready[1]); end
`else
        tests++; if (val(1) !== 32'h0) begin fails++; $display("FAIL nobyp_value: got %h expected 0", val(1)); end
        tests++; if (tg(1) !== 4'd2) begin fails++; $display("FAIL nobyp_tag: got %0d expected 2", tg(1)); end
        tests++; if (rd_ready[1] !== 1'b0) begin fails++; $display("FAIL nobyp_ready: got %b expected 0", rd_ready[1]); end
`endif
        tests++; if (val(0) !== 32'h77) begin fails++; $display("FAIL byp_other_port: got %h expected 77", val(0)); end
        tick();
        tests++; if (val(2) !== 32'h1234) begin fails++; $display("FAIL post_cdb_r10_value: got %h expected 1234", val(2)); end
        tests++; if (rd_ready !== 3'b111) begin fails++; $display("FAIL post_cdb_ready: got %b expected 111", rd_ready); end
        tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL post_cdb_busy: got %0d expected 0", busy_count); end
    endtask

    initial begin
        reset = 1'b1;
        rd_idx = '0;
        rn_en = '0; rn_idx = '0; rn_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        flush = 1'b0;
        test_reset();
        test_rename_cdb();
        test_rename_priority();
        test_cdb_rename_same();
        test_flush();
        test_ignored();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Parametrised register status table for the Tomasulo-style core. It holds the architectural register values plus, per register, the tag of the functional unit that will produce the next value. It supports N read ports, M rename (status-write) ports, and a common-data-bus (CDB) port that writes values and clears statuses on tag match. It also provides a pipeline flush and a busy-register count. It sits between decode/issue (reads, renames) and the CDB arbiter (writeback).

## Interface

Parameters:
- NREG, 32: number of architectural registers; must be a power of two.
- WORD, 32: data width.
- TAG_W, 4: FU tag width; tag 0 is READY.
- RD_PORTS, 3: number of read ports.
- RN_PORTS, 2: number of rename ports; a higher index means later in program order.

Ports:
- clk, in, 1: clock, rising-edge.
- reset, in, 1: reset, asynchronous, active-high.
- rd_idx, in, RD_PORTS*log2(NREG): read indices, packed with port 0 in the LSBs.
- rd_value, out, RD_PORTS*WORD: register values.
- rd_tag, out, RD_PORTS*TAG_W: producer tags.
- rd_ready, out, RD_PORTS: asserted when the corresponding rd_tag == 0.
- rn_en, in, RN_PORTS: rename valid.
- rn_idx, in, RN_PORTS*log2(NREG): destination register per rename port.
- rn_tag, in, RN_PORTS*TAG_W: new producer tag per rename port.
- cdb_valid, in, 1: CDB broadcast valid.
- cdb_tag, in, TAG_W: broadcasting FU tag.
- cdb_data, in, WORD: broadcast result.
- flush, in, 1: mark all registers READY.
- busy_count, out, log2(NREG)+1: number of registers with a non-zero tag.

## Operation

- Reads are combinational: value and tag of rd_idx. Register 0 always reads value 0 with tag 0.
- At each rising edge, for every register r ≠ 0, updates use the tag value from before the edge:
  - **CDB value write:** if cdb_valid, cdb_tag ≠ 0 and tag[r] == cdb_tag, then value[r] ← cdb_data. Every matching register is written in the same cycle.
  - **CDB status clear:** under the same condition, tag[r] ← 0, unless overridden by a rename or flush in that cycle.
  - **Rename:** if some rn_en[k] with rn_idx[k] == r, then tag[r] ← rn_tag of the highest such k. Rename overrides the CDB status clear. The CDB value write still occurs.
  - **Flush:** all tags ← 0. Flush overrides renames and CDB clears. CDB value writes still occur. Register values are never altered by flush.
- Renames targeting register 0 and CDB broadcasts with cdb_tag == 0 are ignored.
- rn_tag == 0 is legal and marks the register READY without changing its value.
- busy_count is a register updated every edge to the popcount of the next-state tags. It therefore reflects the current table contents exactly.
- Reset forces:
  - all values to 0;
  - all tags to 0;
  - busy_count to 0.
  
  Consequently, rd_value = 0, rd_tag = 0 and rd_ready = all ones while reset is asserted. Reset mid-operation discards all pending renames.

## Timing

- Read latency is 0 cycles (combinational from rd_idx and state).
- Rename and CDB effects are visible on reads in the cycle after the edge.
- Without bypass, a CDB result seen at edge n is readable from cycle n+1. Issue logic must snoop the CDB itself during cycle n.
- busy_count latency is 1 cycle after the causing edge.
- Reset is asynchronous assert; deassertion must be synchronous to clk, handled externally.

## Configuration

- Macro: RS_CDB_BYPASS_EN.
- **Defined:** during a cycle in which cdb_valid = 1, cdb_tag ≠ 0, and a read port's stored tag equals cdb_tag, that port outputs:
  - rd_value = cdb_data;
  - rd_tag = 0;
  - rd_ready = 1.
  
  This is combinational, in the same cycle. Sequential behaviour is identical.
- **Undefined:** reads show stored state only.

## Structure

- Package reg_status_pkg holds:
  - TAG_READY = 0;
  - default WORD, TAG_W and NREG;
  - a log2 helper function.
- Sub-module reg_file_mp: a multiport value array with RD_PORTS combinational reads and a per-register write-enable vector (NREG bits) with a shared write-data input. The tag array, priority logic, bypass and busy counter live in reg_status_table.

## Test plan

1. Reset, then read r5 on all ports → value 0, tag 0, ready 1; busy_count 0.
2. Rename r5 → tag 3 on port 0; next cycle CDB tag 3, data 0xDEADBEEF → after the second edge r5 reads 0xDEADBEEF with tag 0, and busy_count goes 0→1→0.
3. Renames in the same cycle: port 0 sets r7 → tag 2 and port 1 sets r7 → tag 4 → r7 tag 4. A CDB on tag 2 the next cycle leaves r7 at tag 4 with its value unchanged.
4. r9 holds tag 6. In the same cycle, CDB tag 6 with data 0x55 and rename r9 → tag 1 → r9 value 0x55, tag 1.
5. Set r1, r2, r3 to tags 1, 2, 3 (busy_count 3), then pulse flush together with a rename of r4 → tag 5 → all tags 0, busy_count 0, values unchanged.
6. With RS_CDB_BYPASS_EN defined: r10 holds tag 2 and CDB tag 2 with data 0x1234 is driven → rd_value = 0x1234 and rd_ready = 1 in the same cycle. Without the macro → tag 2, ready 0 until the next cycle.
